mem_stage_lsu: RTL and testbench

//  MEM-stage load/store unit between EX/MEM pipeline register and MEM/WB register.

---
 rtl/mem_stage_lsu.sv | 110 +++++++++++
 tb/tb_mem_stage_lsu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a valid/ready data-memory port with stall, extension and timeout
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_readM,
  input  logic        mem_writeM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] alu_resultM,
  input  logic [31:0] rd2_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] read_data_m,
  output logic        stall_m,
  output logic        lsu_err,
  output logic        bus_err
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0] f3;
  logic [1:0] a_lo;
  logic access, bad, idle, go, tmo;
  logic [3:0] be_n;
  logic [31:0] wd_n, ext;
  logic [7:0] b_l;
  logic [15:0] h_l;
  assign access = mem_readM | mem_writeM;
  assign bad = (mem_writeM ? (funct3M[2] | &funct3M[1:0]) : (funct3M[1] & (funct3M[0] | funct3M[2])))
             | (funct3M[1:0] == 2'b01 & alu_resultM[0])
             | (funct3M[1:0] == 2'b10 & |alu_resultM[1:0]);
  assign idle = state == S_IDLE;
  assign go = idle & access & ~bad;
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  assign be_n = ~mem_writeM ? 4'hf : funct3M[1] ? 4'hf : funct3M[0] ? (alu_resultM[1] ? 4'hc : 4'h3)
              : 4'b0001 << alu_resultM[1:0];
  assign wd_n = ~mem_writeM ? 32'h0 : funct3M[1] ? rd2_M : funct3M[0] ? {2{rd2_M[15:0]}} : {4{rd2_M[7:0]}};
  assign b_l = dmem_rdata[{a_lo, 3'b000} +: 8];
  assign h_l = a_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign ext = f3[1] ? dmem_rdata : f3[0] ? {{16{~f3[2] & h_l[15]}}, h_l} : {{24{~f3[2] & b_l[7]}}, b_l};
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = go ? S_REQ : S_IDLE;
      S_REQ:  state_n = dmem_ready ? (dmem_we ? S_DONE : S_WAIT) : tmo ? S_DONE : S_REQ;
      S_WAIT: state_n = (dmem_rvalid | tmo) ? S_DONE : S_WAIT;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    lsu_err = reset & idle & access & bad;
    stall_m = reset & (go | state == S_REQ | state == S_WAIT);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      dmem_be <= '0;
      read_data_m <= '0;
      bus_err <= 1'b0;
      cnt <= '0;
      f3 <= '0;
      a_lo <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        S_IDLE:
          if (go) begin
            dmem_req <= 1'b1;
            dmem_we <= mem_writeM;
            dmem_addr <= {alu_resultM[31:2], 2'b00};
            dmem_wdata <= wd_n;
            dmem_be <= be_n;
            f3 <= funct3M;
            a_lo <= alu_resultM[1:0];
            cnt <= '0;
          end
        S_REQ:
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            cnt <= '0;
          end else if (tmo) begin
            dmem_req <= 1'b0;
            bus_err <= 1'b1;
            if (!dmem_we) read_data_m <= '0;
          end else cnt <= cnt + 1'b1;
        S_WAIT:
          if (dmem_rvalid) read_data_m <= ext;
          else if (tmo) begin
            bus_err <= 1'b1;
            read_data_m <= '0;
          end else cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;
  localparam int TO = 4;
  logic clk = 1'b0, reset;
  logic mem_readM, mem_writeM, dmem_ready, dmem_rvalid;
  logic [2:0] funct3M;
  logic [31:0] alu_resultM, rd2_M, dmem_rdata;
  logic dmem_req, dmem_we, stall_m, lsu_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, read_data_m;
  logic [3:0] dmem_be;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} req_t;
  req_t q_req[$];
  logic [31:0] q_rd[$];
  logic [31:0] last_rd = '0;
  int n_cmp = 0, n_err = 0;
  mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .mem_readM(mem_readM), .mem_writeM(mem_writeM), .funct3M(funct3M),
    .alu_resultM(alu_resultM), .rd2_M(rd2_M), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .read_data_m(read_data_m), .stall_m(stall_m),
    .lsu_err(lsu_err), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] data, input logic [31:0] rdata, input int lat, input bit hang,
                    input bit exp_err, input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
    int cyc, rq, exp_st;
    bit rvp;
    req_t e;
    mem_readM = ~wr;
    mem_writeM = wr;
    funct3M = f3;
    alu_resultM = addr;
    rd2_M = data;
    #1;
    chk({tag, "_lsu_err"}, lsu_err, exp_err);
    if (exp_err) begin
      chk({tag, "_err_stall"}, stall_m, 0);
      @(negedge clk); #1;
      chk({tag, "_err_req"}, dmem_req, 0);
      chk({tag, "_err_rd"}, read_data_m, last_rd);
      chk({tag, "_err_stall2"}, stall_m, 0);
    end else begin
      q_req.push_back('{wr, {addr[31:2], 2'b00}, ewd, ebe});
      if (!wr) q_rd.push_back(hang ? 32'h0 : erd);
      exp_st = hang ? 1 + TO : (wr ? 2 : 3) + lat;
      cyc = 0;
      rq = 0;
      rvp = 1'b0;
      while (stall_m && cyc < 40) begin
        if (dmem_req && rq == 0) begin
          chk({tag, "_req_pending"}, 32'(q_req.size()), 1);
          if (q_req.size() > 0) begin
            e = q_req.pop_front();
            chk({tag, "_we"}, dmem_we, e.we);
            chk({tag, "_addr"}, dmem_addr, e.addr);
            chk({tag, "_be"}, dmem_be, e.be);
            chk({tag, "_wdata"}, dmem_wdata, e.wdata);
          end
        end
        dmem_rvalid = rvp;
        dmem_rdata = rvp ? rdata : $urandom;
        dmem_ready = dmem_req && !hang && rq >= lat;
        rvp = dmem_ready && !wr;
        if (dmem_req) rq++;
        cyc++;
        @(negedge clk); #1;
      end
      chk({tag, "_stall_cyc"}, cyc, exp_st);
      chk({tag, "_bus_err"}, bus_err, hang);
      if (!wr && q_rd.size() > 0) begin
        last_rd = q_rd.pop_front();
        chk({tag, "_rdata"}, read_data_m, last_rd);
      end else chk({tag, "_rd_hold"}, read_data_m, last_rd);
    end
    mem_readM = 1'b0;
    mem_writeM = 1'b0;
    dmem_ready = 1'b0;
    dmem_rvalid = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_bus_err_end"}, bus_err, 0);
    chk({tag, "_stall_end"}, stall_m, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    mem_readM = 0; mem_writeM = 0; funct3M = 0; alu_resultM = 0; rd2_M = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    #3 reset = 1'b0;
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_rd", read_data_m, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall", stall_m, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    op("sw",      1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 4'hf, 32'hDEADBEEF, 0);
    op("lb",      0, 3'b000, 32'h103, 0, 32'h80FFFF00, 0, 0, 0, 4'hf, 0, 32'hFFFFFF80);
    op("lbu",     0, 3'b100, 32'h103, 0, 32'h80FFFF00, 0, 0, 0, 4'hf, 0, 32'h00000080);
    op("lhu",     0, 3'b101, 32'h102, 0, 32'h80FFFF00, 0, 0, 0, 4'hf, 0, 32'h000080FF);
    op("lh",      0, 3'b001, 32'h102, 0, 32'h80FFFF00, 0, 0, 0, 4'hf, 0, 32'hFFFF80FF);
    op("lh_lo",   0, 3'b001, 32'h100, 0, 32'h80FFFF00, 0, 0, 0, 4'hf, 0, 32'hFFFFFF00);
    op("lb1",     0, 3'b000, 32'h101, 0, 32'h80FFFF00, 0, 0, 0, 4'hf, 0, 32'hFFFFFFFF);
    op("lb0",     0, 3'b000, 32'h100, 0, 32'h80FFFF00, 0, 0, 0, 4'hf, 0, 32'h00000000);
    op("lw",      0, 3'b010, 32'h104, 0, 32'h80FFFF00, 0, 0, 0, 4'hf, 0, 32'h80FFFF00);
    op("sh_hi",   1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 0, 0, 4'hc, 32'hABCDABCD, 0);
    op("sh_lo",   1, 3'b001, 32'h200, 32'h1234ABCD, 0, 0, 0, 0, 4'h3, 32'hABCDABCD, 0);
    op("sb1",     1, 3'b000, 32'h101, 32'hAAAA0055, 0, 0, 0, 0, 4'h2, 32'h55555555, 0);
    op("sb3",     1, 3'b000, 32'h103, 32'h000000C3, 0, 0, 0, 0, 4'h8, 32'hC3C3C3C3, 0);
    op("lw_mis",  0, 3'b010, 32'h101, 0, 0, 0, 0, 1, 0, 0, 0);
    op("ld_011",  0, 3'b011, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0);
    op("lh_mis",  0, 3'b001, 32'h103, 0, 0, 0, 0, 1, 0, 0, 0);
    op("sh_mis",  1, 3'b001, 32'h101, 32'h1, 0, 0, 0, 1, 0, 0, 0);
    op("st_100",  1, 3'b100, 32'h100, 32'h1, 0, 0, 0, 1, 0, 0, 0);
    op("lw_lat2", 0, 3'b010, 32'h300, 0, 32'h01234567, 2, 0, 0, 4'hf, 0, 32'h01234567);
    op("sw_lat3", 1, 3'b010, 32'h304, 32'h89ABCDEF, 0, 3, 0, 0, 4'hf, 32'h89ABCDEF, 0);
    op("lw_hang", 0, 3'b010, 32'h400, 0, 32'hFFFFFFFF, 0, 1, 0, 4'hf, 0, 0);
    op("lw_ok",   0, 3'b010, 32'h404, 0, 32'hCAFEF00D, 0, 0, 0, 4'hf, 0, 32'hCAFEF00D);
    op("sh_hang", 1, 3'b001, 32'h406, 32'h00007777, 0, 0, 1, 0, 4'hc, 32'h77777777, 0);
    mem_readM = 1'b1;
    funct3M = 3'b010;
    alu_resultM = 32'h500;
    #1;
    @(negedge clk); #1;
    chk("mid_req", dmem_req, 1);
    dmem_ready = 1'b1;
    @(negedge clk); #1;
    dmem_ready = 1'b0;
    chk("mid_wait_stall", stall_m, 1);
    chk("mid_wait_req", dmem_req, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", dmem_we, 0);
    chk("mid_rst_addr", dmem_addr, 0);
    chk("mid_rst_be", dmem_be, 0);
    chk("mid_rst_rd", read_data_m, 0);
    chk("mid_rst_stall", stall_m, 0);
    mem_readM = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h12345678;
    @(negedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("late_rv_rd", read_data_m, 0);
    chk("late_rv_stall", stall_m, 0);
    chk("late_rv_req", dmem_req, 0);
    chk("late_rv_bus_err", bus_err, 0);
    chk("q_req_empty", 32'(q_req.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
